// File: rtl/cpu_pc_if.sv
// Program-counter control/status interface.
// The master side issues fetch control. The slave side (cpu_pc) returns the PC and stack status.
interface cpu_pc_if #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned STACK_DEPTH = 4
);
    localparam int unsigned LVL_W = $clog2(STACK_DEPTH + 1);

    logic             en;
    logic             jmp;
    logic [WIDTH-1:0] jmp_addr;
    logic             call;
    logic             ret;
    logic             halt;
    logic             resume;
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] pc_next;
    logic             halted;
    logic [LVL_W-1:0] stack_level;
    logic             stack_full;
    logic             stack_empty;
    logic             err;

    modport master (
        output en, jmp, jmp_addr, call, ret, halt, resume,
        input  pc_out, pc_next, halted, stack_level, stack_full, stack_empty, err
    );

    modport slave (
        input  en, jmp, jmp_addr, call, ret, halt, resume,
        output pc_out, pc_next, halted, stack_level, stack_full, stack_empty, err
    );
endinterface

// File: rtl/cpu_pc.sv
// Program counter stage with a return-address stack and a RUN/HALTED fetch freeze.
// Optional macro CPU_PC_STACK_ERR_EN: when it is defined, stack overflow or underflow
// sets a sticky ERR flag and forces HALTED.
module cpu_pc #(
    parameter int unsigned     WIDTH       = 8,
    parameter int unsigned     STACK_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic     clk,
    input  logic     rst_n,
    cpu_pc_if.slave  bus
);
    localparam int unsigned LVL_W = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             err_q, err_d;
    logic             push_en;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] top_idx;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] stack_q [STACK_DEPTH];

    assign pc_inc   = pc_q + WIDTH'(1);
    assign push_idx = IDX_W'(level_q);
    assign top_idx  = IDX_W'(level_q - LVL_W'(1));

    // Next-state, next-PC and stack update selection
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        level_d = level_q;
        err_d   = err_q;
        push_en = 1'b0;
        unique case (state_q)
            S_RUN: begin
                if (bus.en) begin
                    if (bus.halt) begin
                        state_d = S_HALTED;
                    end else if (bus.ret) begin
                        if (!empty_q) begin
                            pc_d    = stack_q[top_idx];
                            level_d = level_q - LVL_W'(1);
                        end else begin
`ifdef CPU_PC_STACK_ERR_EN
                            err_d   = 1'b1;
                            state_d = S_HALTED;
`else
                            pc_d    = pc_inc;
`endif
                        end
                    end else if (bus.call) begin
                        if (!full_q) begin
                            push_en = 1'b1;
                            level_d = level_q + LVL_W'(1);
                            pc_d    = bus.jmp_addr;
                        end else begin
`ifdef CPU_PC_STACK_ERR_EN
                            err_d   = 1'b1;
                            state_d = S_HALTED;
`else
                            pc_d    = bus.jmp_addr;
`endif
                        end
                    end else if (bus.jmp) begin
                        pc_d = bus.jmp_addr;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            S_HALTED: begin
                if (bus.resume && !err_q) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
`ifndef CPU_PC_STACK_ERR_EN
        err_d = 1'b0;
`endif
        full_d  = (level_d == LVL_W'(STACK_DEPTH));
        empty_d = (level_d == LVL_W'(0));
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            pc_q    <= RESET_ADDR;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            level_q <= level_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            err_q   <= err_d;
        end
    end

    // Return-address storage; contents are meaningless until pushed, so no reset
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    assign bus.pc_out      = pc_q;
    assign bus.pc_next     = pc_d;
    assign bus.halted      = (state_q == S_HALTED);
    assign bus.stack_level = level_q;
    assign bus.stack_full  = full_q;
    assign bus.stack_empty = empty_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_cpu_pc.sv
// Scoreboard bench for cpu_pc: directed scenarios followed by random traffic, all checked
// against a queue-based reference model.
module tb_cpu_pc;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [7:0] pc;
        bit         halted;
        int         level;
        bit         err;
    } exp_t;

    logic clk;
    logic rst_n;

    cpu_pc_if #(.WIDTH(WIDTH), .STACK_DEPTH(DEPTH)) bus ();

    cpu_pc #(.WIDTH(WIDTH), .STACK_DEPTH(DEPTH), .RESET_ADDR(8'h00)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    exp_t       q_state [$];
    logic [7:0] q_next  [$];

    // Reference model state
    logic [7:0] m_pc;
    logic [7:0] m_stk [$];
    bit         m_halted;
    bit         m_err;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 8'h00;
        m_stk.delete();
        m_halted = 1'b0;
        m_err = 1'b0;
    endtask

    // One clock of the reference model, following the priority rules of the stage
    task automatic model_step(input bit en, input bit jmp, input logic [7:0] addr,
                              input bit call, input bit ret, input bit halt, input bit resume);
        bool_stack: begin end
        if (m_halted) begin
            if (resume && !m_err) m_halted = 1'b0;
        end else if (en) begin
            if (halt) begin
                m_halted = 1'b1;
            end else if (ret) begin
                if (m_stk.size() > 0) begin
                    m_pc = m_stk.pop_back();
                end else begin
`ifdef CPU_PC_STACK_ERR_EN
                    m_err = 1'b1;
                    m_halted = 1'b1;
`else
                    m_pc = m_pc + 8'd1;
`endif
                end
            end else if (call) begin
                if (m_stk.size() < DEPTH) begin
                    m_stk.push_back(m_pc + 8'd1);
                    m_pc = addr;
                end else begin
`ifdef CPU_PC_STACK_ERR_EN
                    m_err = 1'b1;
                    m_halted = 1'b1;
`else
                    m_pc = addr;
`endif
                end
            end else if (jmp) begin
                m_pc = addr;
            end else begin
                m_pc = m_pc + 8'd1;
            end
        end
    endtask

    task automatic set_idle();
        bus.en = 1'b0; bus.jmp = 1'b0; bus.jmp_addr = 8'h00; bus.call = 1'b0;
        bus.ret = 1'b0; bus.halt = 1'b0; bus.resume = 1'b0;
    endtask

    // Drive one cycle of inputs and queue the expected outcome
    task automatic cycle(input bit en, input bit jmp, input logic [7:0] addr,
                         input bit call, input bit ret, input bit halt, input bit resume);
        exp_t e;
        @(negedge clk);
        bus.en = en; bus.jmp = jmp; bus.jmp_addr = addr; bus.call = call;
        bus.ret = ret; bus.halt = halt; bus.resume = resume;
        model_step(en, jmp, addr, call, ret, halt, resume);
        q_next.push_back(m_pc);
        e.pc = m_pc; e.halted = m_halted; e.level = m_stk.size(); e.err = m_err;
        q_state.push_back(e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 8'h00, 0, 0, 0, 0);
    endtask

    task automatic drain();
        int t = 0;
        while ((q_state.size() != 0 || q_next.size() != 0) && t < 10) begin
            @(negedge clk);
            t++;
        end
        if (q_state.size() != 0 || q_next.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d entries left expected 0", q_state.size());
            q_state.delete();
            q_next.delete();
        end
    endtask

    // Assert reset in the middle of the high phase and check outputs clear at once
    task automatic do_reset();
        drain();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        set_idle();
        #1;
        chk("rst_pc", int'(bus.pc_out), 0);
        chk("rst_halted", int'(bus.halted), 0);
        chk("rst_level", int'(bus.stack_level), 0);
        chk("rst_empty", int'(bus.stack_empty), 1);
        chk("rst_full", int'(bus.stack_full), 0);
        chk("rst_err", int'(bus.err), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: combinational next-PC mid-low-phase, registered state just after the edge
    initial begin
        exp_t e;
        logic [7:0] n;
        forever begin
            @(negedge clk);
            #2;
            if (q_next.size() != 0) begin
                n = q_next.pop_front();
                chk("pc_next", int'(bus.pc_next), int'(n));
            end
            @(posedge clk);
            #1;
            if (q_state.size() != 0) begin
                e = q_state.pop_front();
                chk("pc_out", int'(bus.pc_out), int'(e.pc));
                chk("halted", int'(bus.halted), int'(e.halted));
                chk("level", int'(bus.stack_level), e.level);
                chk("full", int'(bus.stack_full), int'(e.level == DEPTH));
                chk("empty", int'(bus.stack_empty), int'(e.level == 0));
                chk("err", int'(bus.err), int'(e.err));
            end
        end
    end

    // Stimulus
    initial begin
        rst_n = 1'b0;
        set_idle();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential increment, then reset in mid-clock
        run(4);
        do_reset();

        // Jump and stall
        cycle(1, 1, 8'h10, 0, 0, 0, 0);
        cycle(1, 1, 8'h40, 0, 0, 0, 0);
        run(1);
        cycle(0, 1, 8'h99, 1, 0, 0, 0);
        cycle(0, 0, 8'h00, 0, 1, 0, 0);

        // Call / return, then CALL+JMP together
        cycle(1, 1, 8'h05, 0, 0, 0, 0);
        cycle(1, 0, 8'h80, 1, 0, 0, 0);
        cycle(1, 0, 8'h00, 0, 1, 0, 0);
        cycle(1, 1, 8'hA0, 1, 0, 0, 0);
        cycle(1, 0, 8'h00, 0, 1, 0, 0);

        // Five nested calls against a four-entry stack
        for (int i = 0; i < 5; i++) cycle(1, 0, 8'(8'h50 + 8'(i * 16)), 1, 0, 0, 0);
        cycle(0, 0, 8'h00, 0, 0, 0, 1);
        cycle(1, 0, 8'h00, 0, 0, 0, 0);
        do_reset();

        // Return on an empty stack at 0x20, then attempt resume
        cycle(1, 1, 8'h20, 0, 0, 0, 0);
        cycle(1, 0, 8'h00, 0, 1, 0, 0);
        cycle(1, 0, 8'h00, 0, 0, 0, 1);
        run(1);
        do_reset();

        // Halt at 0x30, hold with ignored control, resume, then wrap from 0xFF
        cycle(1, 1, 8'h30, 0, 0, 0, 0);
        cycle(1, 0, 8'h00, 0, 0, 1, 0);
        cycle(1, 1, 8'h77, 0, 0, 0, 0);
        cycle(1, 0, 8'h77, 1, 0, 0, 0);
        cycle(1, 0, 8'h00, 0, 1, 0, 0);
        cycle(0, 0, 8'h00, 0, 0, 0, 1);
        run(1);
        cycle(1, 1, 8'hFF, 0, 0, 0, 0);
        run(2);
        // Pushed return address wraps too
        cycle(1, 1, 8'hFF, 0, 0, 0, 0);
        cycle(1, 0, 8'h44, 1, 0, 0, 0);
        cycle(1, 0, 8'h00, 0, 1, 0, 0);

        // Random traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 249) == 0 || (m_err && $urandom_range(0, 15) == 0)) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 99) < 85,
                      $urandom_range(0, 99) < 25,
                      8'($urandom_range(0, 255)),
                      $urandom_range(0, 99) < 20,
                      $urandom_range(0, 99) < 20,
                      $urandom_range(0, 99) < 4,
                      $urandom_range(0, 99) < 30);
            end
        end

        drain();
        @(negedge clk);
        set_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
